// File: rtl/uncached_agent_if.sv
// Single-beat system bus between the uncached agent (master) and the bus fabric (slave).
interface uncached_agent_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  bus_req;
    logic                  bus_wr;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [1:0]            bus_size;
    logic [31:0]           bus_wdata;
    logic                  bus_req_ready;
    logic                  bus_rvalid;
    logic [31:0]           bus_rdata;
    logic                  bus_wack;

    modport master (
        output bus_req, bus_wr, bus_addr, bus_be, bus_size, bus_wdata,
        input  bus_req_ready, bus_rvalid, bus_rdata, bus_wack
    );

    modport slave (
        input  bus_req, bus_wr, bus_addr, bus_be, bus_size, bus_wdata,
        output bus_req_ready, bus_rvalid, bus_rdata, bus_wack
    );
endinterface

// File: rtl/uncached_agent.sv
// Uncached load/store agent: posted stores through an in-order write buffer,
// blocking loads issued only after the buffer has fully drained.
module uncached_agent #(
    parameter int unsigned WBUF_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_paddr,
    input  logic [3:0]            req_byteenable,
    input  logic [31:0]           req_wrdata,
    input  logic [1:0]            req_size,
    output logic                  stall,
    output logic [31:0]           rddata,
    output logic                  wbuf_empty,
    uncached_agent_if.master      bus
);
    localparam int unsigned IDX_W = $clog2(WBUF_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        RD_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] wb_addr [WBUF_DEPTH];
    logic [3:0]            wb_be   [WBUF_DEPTH];
    logic [1:0]            wb_size [WBUF_DEPTH];
    logic [31:0]           wb_data [WBUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             empty, full, push, pop;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
    // full is taken before this cycle's pop, so a store never slips in on the wack cycle
    assign push   = req_valid && req_write && !full;
    assign pop    = (state == WR_WAIT) && bus.bus_wack;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_idx] <= req_paddr;
            wb_be[wr_idx]   <= req_byteenable;
            wb_size[wr_idx] <= req_size;
            wb_data[wr_idx] <= req_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rddata <= '0;
        end else if ((state == RD_WAIT) && bus.bus_rvalid) begin
            rddata <= bus.bus_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Draining writes takes priority over a pending load to keep RAW ordering.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!empty)                       state_next = WR_REQ;
                else if (req_valid && req_read)   state_next = RD_REQ;
            end
            WR_REQ:  if (bus.bus_req_ready) state_next = WR_WAIT;
            WR_WAIT: if (bus.bus_wack)      state_next = IDLE;
            RD_REQ:  if (bus.bus_req_ready) state_next = RD_WAIT;
            RD_WAIT: if (bus.bus_rvalid)    state_next = RD_DONE;
            RD_DONE:                        state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_req   = 1'b0;
        bus.bus_wr    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_be    = '0;
        bus.bus_size  = '0;
        bus.bus_wdata = '0;
        unique case (state)
            WR_REQ: begin
                bus.bus_req   = 1'b1;
                bus.bus_wr    = 1'b1;
                bus.bus_addr  = wb_addr[rd_idx];
                bus.bus_be    = wb_be[rd_idx];
                bus.bus_size  = wb_size[rd_idx];
                bus.bus_wdata = wb_data[rd_idx];
            end
            RD_REQ: begin
                bus.bus_req   = 1'b1;
                bus.bus_addr  = req_paddr;
                bus.bus_be    = req_byteenable;
                bus.bus_size  = req_size;
            end
            default: ;
        endcase

        stall      = req_valid && ((req_write && full) ||
                                   (req_read && (state != RD_DONE)));
        wbuf_empty = empty && (state != WR_REQ) && (state != WR_WAIT);
    end
endmodule
